// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline stage: two-entry skid register with valid/ready handshake and flush.
// Also produces the write-back mux result and the gated register-write strobe.
module mem_wb_skid_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int CTRL_W = 2,
    parameter int SKID   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [RD_W-1:0]   rd_addr_i,
    input  logic [DATA_W-1:0] instr_i,
    input  logic [DATA_W-1:0] mem_i,
    input  logic [DATA_W-1:0] alu_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [RD_W-1:0]   rd_addr_o,
    output logic [DATA_W-1:0] instr_o,
    output logic [DATA_W-1:0] mem_o,
    output logic [DATA_W-1:0] alu_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              reg_write_o,
    output logic [1:0]        occupancy_o
);

    localparam int ENTRY_W   = CTRL_W + RD_W + 3 * DATA_W;
    localparam int MEM_LSB   = DATA_W;
    localparam int INSTR_LSB = 2 * DATA_W;
    localparam int RD_LSB    = 3 * DATA_W;
    localparam int CTRL_LSB  = 3 * DATA_W + RD_W;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    occ_e               state_r;
    occ_e               state_s;
    logic [ENTRY_W-1:0] main_r;
    logic [ENTRY_W-1:0] skid_r;
    logic [ENTRY_W-1:0] in_entry_s;
    logic               in_fire_s;
    logic               out_fire_s;
    logic               load_main_s;
    logic               load_skid_s;
    logic               pop_skid_s;
    logic               valid_s;
    logic               ready_s;
    logic [CTRL_W-1:0]  head_ctrl_s;
    logic [RD_W-1:0]    head_rd_s;

    assign in_entry_s  = {ctrl_i, rd_addr_i, instr_i, mem_i, alu_i};
    assign valid_s     = (state_r != OCC_EMPTY);
    assign in_fire_s   = valid_i & ready_s;
    assign out_fire_s  = valid_s & ready_i;
    assign head_ctrl_s = main_r[CTRL_LSB +: CTRL_W];
    assign head_rd_s   = main_r[RD_LSB +: RD_W];

    // With SKID the ready flag is registered from the next occupancy, cutting any path from ready_i.
    if (SKID != 0) begin : g_skid
        logic ready_r;

        // Ready register: low only while both entries are held.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                ready_r <= 1'b1;
            end else begin
                ready_r <= (state_s != OCC_TWO);
            end
        end

        assign ready_s = ready_r;
    end else begin : g_single
        // Single entry: TWO is unreachable because an accept in ONE always coincides with a drain.
        assign ready_s = ~valid_s | ready_i;
    end

    // Occupancy state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= OCC_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Next occupancy; flush overrides every handshake event.
    always_comb begin
        state_s = state_r;
        if (flush_i) begin
            state_s = OCC_EMPTY;
        end else begin
            case (state_r)
                OCC_EMPTY: begin
                    if (in_fire_s) state_s = OCC_ONE;
                    else           state_s = OCC_EMPTY;
                end
                OCC_ONE: begin
                    if (in_fire_s && !out_fire_s)      state_s = OCC_TWO;
                    else if (!in_fire_s && out_fire_s) state_s = OCC_EMPTY;
                    else                               state_s = OCC_ONE;
                end
                OCC_TWO: begin
                    if (out_fire_s) state_s = OCC_ONE;
                    else            state_s = OCC_TWO;
                end
                default: state_s = OCC_EMPTY;
            endcase
        end
    end

    // Entry-move strobes derived from the current occupancy and both handshakes.
    always_comb begin
        load_main_s = 1'b0;
        load_skid_s = 1'b0;
        pop_skid_s  = 1'b0;
        if (flush_i) begin
            load_main_s = 1'b0;
        end else begin
            case (state_r)
                OCC_EMPTY: load_main_s = in_fire_s;
                OCC_ONE: begin
                    load_main_s = in_fire_s & out_fire_s;
                    load_skid_s = in_fire_s & ~out_fire_s;
                end
                OCC_TWO:   pop_skid_s  = out_fire_s;
                default:   load_main_s = 1'b0;
            endcase
        end
    end

    // Main (head) and skid entry registers; contents are left as-is on flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_r <= {ENTRY_W{1'b0}};
            skid_r <= {ENTRY_W{1'b0}};
        end else begin
            if (load_main_s) begin
                main_r <= in_entry_s;
            end else if (pop_skid_s) begin
                main_r <= skid_r;
            end
            if (load_skid_s) begin
                skid_r <= in_entry_s;
            end
        end
    end

    // Head decode: control is masked on a bubble so the write strobe drops with it.
    always_comb begin
        valid_o     = valid_s;
        ready_o     = ready_s;
        occupancy_o = state_r;
        rd_addr_o   = head_rd_s;
        instr_o     = main_r[INSTR_LSB +: DATA_W];
        mem_o       = main_r[MEM_LSB +: DATA_W];
        alu_o       = main_r[0 +: DATA_W];
        if (valid_s) begin
            ctrl_o = head_ctrl_s;
        end else begin
            ctrl_o = {CTRL_W{1'b0}};
        end
        if (valid_s && head_ctrl_s[0]) begin
            wb_data_o = main_r[MEM_LSB +: DATA_W];
        end else begin
            wb_data_o = main_r[0 +: DATA_W];
        end
        reg_write_o = valid_s & head_ctrl_s[1] & (head_rd_s != {RD_W{1'b0}});
    end

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Self-checking bench for mem_wb_skid_stage: negedge scoreboard plus per-scenario tasks.
`timescale 1ns/1ps
module tb_mem_wb_skid_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [1:0]  ctrl_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] instr_i;
    logic [31:0] mem_i;
    logic [31:0] alu_i;
    logic        valid_o;
    logic        ready_i;
    logic [1:0]  ctrl_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] instr_o;
    logic [31:0] mem_o;
    logic [31:0] alu_o;
    logic [31:0] wb_data_o;
    logic        reg_write_o;
    logic [1:0]  occupancy_o;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] wb;
        logic        rw;
        logic [4:0]  rd;
        logic [1:0]  ctrl;
        logic [31:0] alu;
    } exp_t;

    exp_t sb_q[$];

    mem_wb_skid_stage #(.DATA_W(32), .RD_W(5), .CTRL_W(2), .SKID(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o), .ctrl_i(ctrl_i),
        .rd_addr_i(rd_addr_i), .instr_i(instr_i), .mem_i(mem_i), .alu_i(alu_i),
        .valid_o(valid_o), .ready_i(ready_i), .ctrl_o(ctrl_o),
        .rd_addr_o(rd_addr_o), .instr_o(instr_o), .mem_o(mem_o), .alu_o(alu_o),
        .wb_data_o(wb_data_o), .reg_write_o(reg_write_o), .occupancy_o(occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic exp_t make_exp(input logic [1:0] c, input logic [4:0] rd,
                                      input logic [31:0] m, input logic [31:0] a);
        exp_t e;
        e.wb   = c[0] ? m : a;
        e.rw   = c[1] && (rd != 5'd0);
        e.rd   = rd;
        e.ctrl = c;
        e.alu  = a;
        return e;
    endfunction

    // Reset discards everything the model holds.
    always @(posedge rst_i) sb_q.delete();

    // Scoreboard: compare head against the oldest expected entry, then apply this edge's handshakes.
    always @(negedge clk_i) begin : mon
        int   n;
        exp_t e;
        logic in_f;
        if (!rst_i) begin
            n = sb_q.size();
            vectors++;
            if (occupancy_o !== 2'(n) || valid_o !== (n != 0) || ready_o !== (n < 2)) begin
                miscompares++;
                $display("FAIL sb_state: occupancy=%0d valid=%b ready=%b, required occupancy=%0d valid=%b ready=%b",
                         occupancy_o, valid_o, ready_o, n, (n != 0), (n < 2));
            end
            vectors++;
            if (n != 0) begin
                e = sb_q[0];
                if (wb_data_o !== e.wb || reg_write_o !== e.rw || rd_addr_o !== e.rd ||
                    ctrl_o !== e.ctrl || alu_o !== e.alu) begin
                    miscompares++;
                    $display("FAIL sb_head: wb=%h rw=%b rd=%0d ctrl=%b alu=%h, required wb=%h rw=%b rd=%0d ctrl=%b alu=%h",
                             wb_data_o, reg_write_o, rd_addr_o, ctrl_o, alu_o,
                             e.wb, e.rw, e.rd, e.ctrl, e.alu);
                end
            end else begin
                if (reg_write_o !== 1'b0 || ctrl_o !== 2'b00) begin
                    miscompares++;
                    $display("FAIL sb_bubble: rw=%b ctrl=%b, required rw=0 ctrl=00", reg_write_o, ctrl_o);
                end
            end
            in_f = valid_i && (n < 2);
            if (flush_i) begin
                sb_q.delete();
            end else begin
                if (n != 0 && ready_i) void'(sb_q.pop_front());
                if (in_f) sb_q.push_back(make_exp(ctrl_i, rd_addr_i, mem_i, alu_i));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] c, input logic [4:0] rd,
                         input logic [31:0] m, input logic [31:0] a);
        valid_i   = v;
        ctrl_i    = c;
        rd_addr_i = rd;
        mem_i     = m;
        alu_i     = a;
        instr_i   = a ^ 32'hA5A5_0000;
    endtask

    task automatic test_reset();
        vectors++;
        if (valid_o !== 1'b0 || reg_write_o !== 1'b0 || ready_o !== 1'b1 || occupancy_o !== 2'd0 ||
            wb_data_o !== 32'h0 || ctrl_o !== 2'b00 || alu_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reset: valid=%b rw=%b ready=%b occ=%0d wb=%h, required 0 0 1 0 0",
                     valid_o, reg_write_o, ready_o, occupancy_o, wb_data_o);
        end
        repeat (2) tick();
        vectors++;
        if (valid_o !== 1'b0 || reg_write_o !== 1'b0 || ready_o !== 1'b1 || occupancy_o !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_idle: valid=%b rw=%b ready=%b occ=%0d, required 0 0 1 0",
                     valid_o, reg_write_o, ready_o, occupancy_o);
        end
    endtask

    task automatic test_stream();
        logic [31:0] vals [3];
        vals[0] = 32'h10; vals[1] = 32'h20; vals[2] = 32'h30;
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b10, 5'd5, 32'hFFFF_0000, vals[i]);
            tick();
            vectors++;
            if (wb_data_o !== vals[i] || reg_write_o !== 1'b1 || valid_o !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_%0d: wb=%h rw=%b valid=%b, required wb=%h rw=1 valid=1",
                         i, wb_data_o, reg_write_o, valid_o, vals[i]);
            end
        end
        drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        tick();
        vectors++;
        if (valid_o !== 1'b0 || reg_write_o !== 1'b0 || alu_o !== 32'h30) begin
            miscompares++;
            $display("FAIL stream_bubble: valid=%b rw=%b alu=%h, required 0 0 00000030",
                     valid_o, reg_write_o, alu_o);
        end
    endtask

    task automatic test_stall();
        ready_i = 1'b0;
        drive(1'b1, 2'b10, 5'd3, 32'h0, 32'h100);
        tick();
        vectors++;
        if (occupancy_o !== 2'd1 || ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_one: occ=%0d ready=%b, required 1 1", occupancy_o, ready_o);
        end
        drive(1'b1, 2'b10, 5'd3, 32'h0, 32'h101);
        tick();
        vectors++;
        if (occupancy_o !== 2'd2 || ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_two: occ=%0d ready=%b, required 2 0", occupancy_o, ready_o);
        end
        drive(1'b1, 2'b10, 5'd3, 32'h0, 32'h102);
        tick();
        vectors++;
        if (occupancy_o !== 2'd2 || ready_o !== 1'b0 || wb_data_o !== 32'h100) begin
            miscompares++;
            $display("FAIL stall_hold: occ=%0d ready=%b wb=%h, required 2 0 00000100",
                     occupancy_o, ready_o, wb_data_o);
        end
        ready_i = 1'b1;
        tick();
        vectors++;
        if (occupancy_o !== 2'd1 || wb_data_o !== 32'h101) begin
            miscompares++;
            $display("FAIL stall_drain1: occ=%0d wb=%h, required 1 00000101", occupancy_o, wb_data_o);
        end
        tick();
        vectors++;
        if (occupancy_o !== 2'd1 || wb_data_o !== 32'h102) begin
            miscompares++;
            $display("FAIL stall_drain2: occ=%0d wb=%h, required 1 00000102", occupancy_o, wb_data_o);
        end
        drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        tick();
        vectors++;
        if (occupancy_o !== 2'd0 || valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_empty: occ=%0d valid=%b, required 0 0", occupancy_o, valid_o);
        end
    endtask

    task automatic test_load_x0();
        ready_i = 1'b1;
        drive(1'b1, 2'b11, 5'd7, 32'hDEAD_BEEF, 32'h4);
        tick();
        vectors++;
        if (wb_data_o !== 32'hDEAD_BEEF || reg_write_o !== 1'b1) begin
            miscompares++;
            $display("FAIL load: wb=%h rw=%b, required deadbeef 1", wb_data_o, reg_write_o);
        end
        drive(1'b1, 2'b11, 5'd0, 32'hDEAD_BEEF, 32'h4);
        tick();
        vectors++;
        if (wb_data_o !== 32'hDEAD_BEEF || reg_write_o !== 1'b0 || valid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL load_x0: wb=%h rw=%b valid=%b, required deadbeef 0 1",
                     wb_data_o, reg_write_o, valid_o);
        end
        drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_flush();
        ready_i = 1'b0;
        drive(1'b1, 2'b10, 5'd9, 32'h0, 32'h200);
        tick();
        drive(1'b1, 2'b10, 5'd9, 32'h0, 32'h201);
        tick();
        vectors++;
        if (occupancy_o !== 2'd2) begin
            miscompares++;
            $display("FAIL flush_fill: occ=%0d, required 2", occupancy_o);
        end
        drive(1'b1, 2'b10, 5'd9, 32'h0, 32'hBAD);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        vectors++;
        if (valid_o !== 1'b0 || occupancy_o !== 2'd0 || ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_two: valid=%b occ=%0d ready=%b, required 0 0 1",
                     valid_o, occupancy_o, ready_o);
        end
        drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        ready_i = 1'b1;
        repeat (2) tick();
        vectors++;
        if (valid_o !== 1'b0 || alu_o === 32'hBAD) begin
            miscompares++;
            $display("FAIL flush_gone: valid=%b alu=%h, required valid 0 and alu not 00000bad", valid_o, alu_o);
        end
        // Flush while in ONE with a live accept: the accept is dropped.
        ready_i = 1'b0;
        drive(1'b1, 2'b10, 5'd9, 32'h0, 32'h300);
        tick();
        drive(1'b1, 2'b10, 5'd9, 32'h0, 32'h301);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        tick();
        vectors++;
        if (valid_o !== 1'b0 || occupancy_o !== 2'd0 || ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_one: valid=%b occ=%0d ready=%b, required 0 0 1",
                     valid_o, occupancy_o, ready_o);
        end
    endtask

    task automatic test_async_reset();
        ready_i = 1'b0;
        drive(1'b1, 2'b10, 5'd4, 32'h0, 32'h400);
        tick();
        drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        vectors++;
        if (occupancy_o !== 2'd1 || valid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_pre: occ=%0d valid=%b, required 1 1", occupancy_o, valid_o);
        end
        #1 rst_i = 1'b1;
        #1;
        vectors++;
        if (valid_o !== 1'b0 || occupancy_o !== 2'd0 || ready_o !== 1'b1 ||
            reg_write_o !== 1'b0 || alu_o !== 32'h0) begin
            miscompares++;
            $display("FAIL areset_now: valid=%b occ=%0d ready=%b rw=%b alu=%h, required 0 0 1 0 0",
                     valid_o, occupancy_o, ready_o, reg_write_o, alu_o);
        end
        #1 rst_i = 1'b0;
        tick();
        ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'b10, 5'd6, 32'h0, 32'h500 + 32'(i));
            tick();
            vectors++;
            if (wb_data_o !== (32'h500 + 32'(i)) || reg_write_o !== 1'b1) begin
                miscompares++;
                $display("FAIL areset_resume_%0d: wb=%h rw=%b, required %h 1",
                         i, wb_data_o, reg_write_o, 32'h500 + 32'(i));
            end
        end
        drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        tick();
        vectors++;
        if (occupancy_o !== 2'd0) begin
            miscompares++;
            $display("FAIL areset_end: occ=%0d, required 0", occupancy_o);
        end
    endtask

    initial begin
        rst_i   = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b0;
        drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        #1 rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_load_x0();
        test_flush();
        test_async_reset();
        repeat (2) tick();
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: %0d entries pending, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
